// File: rtl/phase_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : phase_sweep_gen
// Purpose  : Generates a paced sweep of signed Fix48_45 phase words for the
//            CORDIC sin/cos core. Each new word is the previous word plus a
//            signed step, wrapped back into [-pi, +pi]. The output is a
//            valid-only stream because the core cannot apply back-pressure.
// Ports    : clk          - clock, all state changes on the rising edge
//            rst          - asynchronous reset, active low
//            start        - one-cycle sweep request, looked at only when idle
//            abort        - ends a running sweep without a done pulse
//            phase_start  - first phase word (captured with start)
//            phase_step   - signed per-sample increment (captured with start)
//            num_samples  - number of samples to emit (captured with start)
//            interval     - idle cycles between samples (captured with start)
//            datao/valido - phase word and its single-cycle valid
//            busy         - high while a sweep is running
//            done         - one-cycle pulse after the final sample
//            err          - one-cycle pulse when a start is rejected
// Revision : 1.0 - initial release
// ============================================================================
module phase_sweep_gen #(
  parameter int             PW    = 48,
  parameter int             CNTW  = 32,
  parameter int             DIVW  = 16,
  parameter logic [PW-1:0]  PI_FX = 48'h6487ED5110B4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [PW-1:0]   phase_start,
  input  logic [PW-1:0]   phase_step,
  input  logic [CNTW-1:0] num_samples,
  input  logic [DIVW-1:0] interval,
  output logic [PW-1:0]   datao,
  output logic            valido,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Wrap arithmetic runs one bit wider than the phase word so that a sum of
  // two in-range values (up to +/-2pi) cannot overflow before correction.
  localparam logic [PW:0]   c_PI_EXT   = {1'b0, PI_FX};
  localparam logic [PW:0]   c_NPI_EXT  = -c_PI_EXT;
  localparam logic [PW-1:0] c_NPI      = -PI_FX;
  localparam logic [PW:0]   c_TWO_PI   = {PI_FX, 1'b0};
  localparam logic [PW-1:0] c_TWO_PI_L = c_TWO_PI[PW-1:0];
  localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [DIVW-1:0] c_DIV_ONE = {{(DIVW-1){1'b0}}, 1'b1};

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_phase, w_phase_nxt;
  logic [PW-1:0]   r_step,  w_step_nxt;
  logic [CNTW-1:0] r_left,  w_left_nxt;
  logic [DIVW-1:0] r_gap,   w_gap_nxt;
  logic [DIVW-1:0] r_ivl,   w_ivl_nxt;
  logic [PW-1:0]   r_datao, w_datao_nxt;
  logic            r_valido, w_valido_nxt;
  logic            r_done,   w_done_nxt;
  logic            r_err,    w_err_nxt;

  // Shared adder: in IDLE it pre-computes the second sample from the start
  // inputs, in RUN it advances the latched phase.
  logic [PW-1:0] w_add_a, w_add_b, w_phase_adv;
  logic [PW:0]   w_sum;
  logic          w_over, w_under, w_bad_cfg;

  assign w_add_a = (r_state == S_IDLE) ? phase_start : r_phase;
  assign w_add_b = (r_state == S_IDLE) ? phase_step  : r_step;
  assign w_sum   = {w_add_a[PW-1], w_add_a} + {w_add_b[PW-1], w_add_b};
  assign w_over  = $signed(w_sum) > $signed(c_PI_EXT);
  assign w_under = $signed(w_sum) < $signed(c_NPI_EXT);

  // Correction is done on the truncated word: subtracting 2pi modulo 2^PW
  // gives the same low bits as subtracting it at full width.
  always_comb begin
    w_phase_adv = w_sum[PW-1:0];
    if (w_over) begin
      w_phase_adv = w_sum[PW-1:0] - c_TWO_PI_L;
    end else if (w_under) begin
      w_phase_adv = w_sum[PW-1:0] + c_TWO_PI_L;
    end
  end

  assign w_bad_cfg = ($signed(phase_start) > $signed(PI_FX)) ||
                     ($signed(phase_start) < $signed(c_NPI)) ||
                     ($signed(phase_step)  > $signed(PI_FX)) ||
                     ($signed(phase_step)  < $signed(c_NPI));

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_step_nxt   = r_step;
    w_left_nxt   = r_left;
    w_gap_nxt    = r_gap;
    w_ivl_nxt    = r_ivl;
    w_datao_nxt  = r_datao;
    w_valido_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad_cfg) begin
            w_err_nxt = 1'b1;
          end else if (num_samples == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            // First sample leaves on the accepting edge, so the phase
            // register already holds the second sample afterwards.
            w_state_nxt  = S_RUN;
            w_datao_nxt  = phase_start;
            w_valido_nxt = 1'b1;
            w_phase_nxt  = w_phase_adv;
            w_step_nxt   = phase_step;
            w_left_nxt   = num_samples - c_CNT_ONE;
            w_gap_nxt    = interval;
            w_ivl_nxt    = interval;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_left == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_gap == '0) begin
          w_datao_nxt  = r_phase;
          w_valido_nxt = 1'b1;
          w_phase_nxt  = w_phase_adv;
          w_left_nxt   = r_left - c_CNT_ONE;
          w_gap_nxt    = r_ivl;
        end else begin
          w_gap_nxt = r_gap - c_DIV_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_step   <= '0;
      r_left   <= '0;
      r_gap    <= '0;
      r_ivl    <= '0;
      r_datao  <= '0;
      r_valido <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_step   <= w_step_nxt;
      r_left   <= w_left_nxt;
      r_gap    <= w_gap_nxt;
      r_ivl    <= w_ivl_nxt;
      r_datao  <= w_datao_nxt;
      r_valido <= w_valido_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign datao  = r_datao;
  assign valido = r_valido;
  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_phase_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sweep_gen
// Purpose  : Self-checking bench for phase_sweep_gen. A cycle model built on
//            plain integer arithmetic predicts every output each cycle;
//            directed sweeps additionally pin sample values and timing with
//            hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sweep_gen;

  localparam longint c_PI = 64'sh00006487ED5110B4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [47:0] phase_start, phase_step;
  logic [31:0] num_samples;
  logic [15:0] interval;
  logic [47:0] datao;
  logic        valido, busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_sweep_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .phase_start(phase_start), .phase_step(phase_step),
    .num_samples(num_samples), .interval(interval),
    .datao(datao), .valido(valido), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input logic [47:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint mwrap(input longint s);
    if (s > c_PI)  return s - 2 * c_PI;
    if (s < -c_PI) return s + 2 * c_PI;
    return s;
  endfunction

  // Edge counter: value read at a posedge is that edge's index; value seen
  // at the following negedge is index+1 (the cycle after the edge).
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  bit          m_run;
  longint      m_left, m_ivl, m_gap, m_ph, m_step;
  bit          e_valid, e_busy, e_done, e_err;
  logic [47:0] e_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; e_valid = 0; e_busy = 0; e_done = 0; e_err = 0; e_data = '0;
    end else begin
      e_valid = 0; e_done = 0; e_err = 0;
      if (!m_run) begin
        if (start) begin
          if (sx(phase_start) > c_PI || sx(phase_start) < -c_PI ||
              sx(phase_step) > c_PI || sx(phase_step) < -c_PI) begin
            e_err = 1;
          end else if (num_samples == 0) begin
            e_done = 1;
          end else begin
            m_run = 1; m_left = {32'd0, num_samples}; m_ivl = {48'd0, interval};
            m_step = sx(phase_step); m_ph = sx(phase_start); m_gap = 0;
            e_valid = 1; e_data = m_ph[47:0]; m_left--; m_ph = mwrap(m_ph + m_step);
          end
        end
      end else if (abort) begin
        m_run = 0;
      end else if (m_left == 0) begin
        m_run = 0; e_done = 1;
      end else begin
        m_gap++;
        if (m_gap == m_ivl + 1) begin
          e_valid = 1; e_data = m_ph[47:0]; m_left--; m_ph = mwrap(m_ph + m_step); m_gap = 0;
        end
      end
      e_busy = m_run;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("valido", {63'd0, valido}, {63'd0, e_valid});
      chk("busy",   {63'd0, busy},   {63'd0, e_busy});
      chk("done",   {63'd0, done},   {63'd0, e_done});
      chk("err",    {63'd0, err},    {63'd0, e_err});
      if (e_valid) chk("datao", {16'd0, datao}, {16'd0, e_data});
    end
  end

  // ---------------- capture for literal checks ----------------
  logic [47:0] cap_data[$];
  longint      cap_cyc[$];
  longint      done_cyc, err_cyc;

  always @(negedge clk) begin
    if (rst) begin
      if (valido) begin cap_data.push_back(datao); cap_cyc.push_back(cyc); end
      if (done) done_cyc = cyc;
      if (err)  err_cyc  = cyc;
    end
  end

  task automatic go(input logic [47:0] ps, input logic [47:0] st,
                    input logic [31:0] n, input logic [15:0] iv, output longint t);
    @(negedge clk);
    cap_data.delete(); cap_cyc.delete(); done_cyc = -1; err_cyc = -1;
    phase_start = ps; phase_step = st; num_samples = n; interval = iv; start = 1'b1;
    @(posedge clk);
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  longint t;

  initial begin
    rst = 1'b0; start = 0; abort = 0;
    phase_start = '0; phase_step = '0; num_samples = '0; interval = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("reset datao", {16'd0, datao}, 64'd0);
    chk("reset flags", {60'd0, valido, busy, done, err}, 64'd0);

    // Basic sweep
    go(48'h0, 48'h000100000000, 32'd4, 16'd0, t);
    repeat (8) @(negedge clk);
    chk("basic count", cap_data.size(), 64'd4);
    if (cap_data.size() == 4) begin
      chk("basic d0", {16'd0, cap_data[0]}, 64'h0);
      chk("basic d1", {16'd0, cap_data[1]}, 64'h000100000000);
      chk("basic d2", {16'd0, cap_data[2]}, 64'h000200000000);
      chk("basic d3", {16'd0, cap_data[3]}, 64'h000300000000);
      chk("basic first cyc", cap_cyc[0], t + 1);
      chk("basic last cyc",  cap_cyc[3], t + 4);
    end
    chk("basic done cyc", done_cyc, t + 5);

    // Positive wrap
    go(48'h6487ED5110B3, 48'h2, 32'd2, 16'd0, t);
    repeat (5) @(negedge clk);
    chk("poswrap count", cap_data.size(), 64'd2);
    if (cap_data.size() == 2) begin
      chk("poswrap d0", {16'd0, cap_data[0]}, 64'h6487ED5110B3);
      chk("poswrap d1", {16'd0, cap_data[1]}, 64'h9B7812AEEF4D);
    end

    // Negative wrap with exact -pi kept
    go(48'h9B7812AEEF4D, 48'hFFFFFFFFFFFF, 32'd3, 16'd0, t);
    repeat (6) @(negedge clk);
    chk("negwrap count", cap_data.size(), 64'd3);
    if (cap_data.size() == 3) begin
      chk("negwrap d0", {16'd0, cap_data[0]}, 64'h9B7812AEEF4D);
      chk("negwrap d1", {16'd0, cap_data[1]}, 64'h9B7812AEEF4C);
      chk("negwrap d2", {16'd0, cap_data[2]}, 64'h6487ED5110B3);
    end

    // Pacing
    go(48'h100, 48'h1000, 32'd3, 16'd3, t);
    repeat (12) @(negedge clk);
    chk("pace count", cap_data.size(), 64'd3);
    if (cap_data.size() == 3) begin
      chk("pace c0", cap_cyc[0], t + 1);
      chk("pace c1", cap_cyc[1], t + 5);
      chk("pace c2", cap_cyc[2], t + 9);
      chk("pace d2", {16'd0, cap_data[2]}, 64'h2100);
    end
    chk("pace done cyc", done_cyc, t + 10);

    // Rejected step
    go(48'h0, 48'h6487ED5110B5, 32'd4, 16'd0, t);
    repeat (4) @(negedge clk);
    chk("reject err cyc", err_cyc, t + 1);
    chk("reject no valid", cap_data.size(), 64'd0);

    // Zero samples
    go(48'h0, 48'h1, 32'd0, 16'd0, t);
    repeat (4) @(negedge clk);
    chk("zero done cyc", done_cyc, t + 1);
    chk("zero no valid", cap_data.size(), 64'd0);

    // Start while running is ignored
    go(48'h0, 48'h10, 32'd4, 16'd1, t);
    @(negedge clk);
    phase_start = 48'h5; phase_step = 48'h1; num_samples = 32'd1; interval = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("runstart count", cap_data.size(), 64'd4);
    if (cap_data.size() == 4) chk("runstart d3", {16'd0, cap_data[3]}, 64'h30);
    chk("runstart done cyc", done_cyc, t + 8);
    chk("runstart no err", err_cyc, -64'sd1);

    // Abort before the third sample
    go(48'h0, 48'h1, 32'd8, 16'd0, t);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort count", cap_data.size(), 64'd2);
    chk("abort no done", done_cyc, -64'sd1);

    // Asynchronous reset mid-sweep, then a normal sweep
    go(48'h0, 48'h1, 32'd10, 16'd0, t);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async datao", {16'd0, datao}, 64'd0);
    chk("async flags", {60'd0, valido, busy, done, err}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset idle", {60'd0, valido, busy, done, err}, 64'd0);
    go(48'h0, 48'h000100000000, 32'd4, 16'd0, t);
    repeat (8) @(negedge clk);
    chk("restart count", cap_data.size(), 64'd4);
    chk("restart done cyc", done_cyc, t + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_sweep_gen.md
# phase_sweep_gen

Upstream stimulus stage for the CORDIC sin/cos core: generates a programmable sweep of 48-bit fixed-point phase words, wrapped into [-pi, +pi]. Output drives the core's phase input (`s_axis_phase_tdata` / `s_axis_phase_tvalid`) directly. The core has no back-pressure, so this block emits a valid-only stream. The sweep is paced by a programmable inter-sample interval and bounded by a sample count.

## Interface

- PW, 48: phase word width, signed two's complement, Fix48_45 (1 sign, 2 integer, 45 fractional bits, radians).
- CNTW, 32: sample-count width.
- DIVW, 16: interval-counter width.
- PI_FX, 48'h6487ED5110B4: round(pi·2^45); 2·PI_FX = 48'hC90FDAA22168.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  terminates a running sweep.
- phase_start  in  PW  first phase word; sampled with start.
- phase_step  in  PW  signed increment per sample; sampled with start.
- num_samples  in  CNTW  samples to emit; sampled with start.
- interval  in  DIVW  idle cycles between samples (0 = every cycle); sampled with start.
- datao  out  PW  phase word to CORDIC.
- valido  out  1  datao valid, single-cycle per sample.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal sweep completion.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation

- States: IDLE, RUN. Reset enters IDLE.
- IDLE, start=1:
  - If phase_start or phase_step lies outside [-PI_FX, +PI_FX] (signed compare): pulse err next cycle, stay IDLE.
  - Else if num_samples=0: pulse done next cycle, stay IDLE. No valido.
  - Else: latch step, count, interval and phase_start into the phase register; go to RUN.
- RUN:
  - On each emission, drive datao=phase register with valido=1.
  - Update phase: sum = sext(phase)+sext(step) at PW+1 bits.
    - If sum > PI_FX, next = sum − 2·PI_FX.
    - If sum < −PI_FX, next = sum + 2·PI_FX.
    - Otherwise next = sum.
    - Truncate to PW. One correction suffices because |step| ≤ pi.
  - Result exactly ±PI_FX is kept as is, with no wrap.
  - Decrement the remaining count on each emission.
  - Between emissions, an interval counter counts `interval` idle cycles with valido=0.
  - When the last sample is emitted: next cycle done=1, busy=0, state IDLE.
- abort in RUN: return to IDLE next cycle with no further valido and no done. abort in IDLE is ignored.
- start while RUN is ignored: no err, config unchanged.
- abort and start together in IDLE: start wins.

## Timing

- Reset values: datao=0, valido=0, busy=0, done=0, err=0, all internal counters 0.
- Latency: start accepted at edge t → first valido at cycle t+1, datao=phase_start, busy=1 from t+1.
- Sample spacing: valido pulses are exactly interval+1 cycles apart. For interval=0, valido is continuous for num_samples cycles.
- done asserts one cycle after the last valido. busy drops in the same cycle.
- abort sampled at edge t: valido=0 and busy=0 from t+1, even if a sample was due.
- Reset asserted mid-sweep: outputs go to reset values immediately (asynchronous), state IDLE. Restart requires a new start after deassertion.
- done, err and valido are registered outputs with no combinational path from inputs.

## Test plan

- Basic sweep: start, phase_start=0, phase_step=48'h000100000000, num_samples=4, interval=0 → valido on 4 consecutive cycles from t+1, datao=0, 0x100000000, 0x200000000, 0x300000000; done at t+5.
- Positive wrap: phase_start=PI_FX−1, step=2, num=2 → datao=PI_FX−1, then (PI_FX+1)−2·PI_FX = −PI_FX+1 (48'h9B7812AEEF4D).
- Negative wrap and exact boundary: phase_start=−PI_FX+1, step=−1, num=3 → −PI_FX+1, −PI_FX (no wrap), then PI_FX−1.
- Pacing: interval=3, num=3 → valido at t+1, t+5, t+9; done at t+10; busy high t+1..t+9.
- Rejects and degenerate starts:
  - phase_step=PI_FX+1 → err pulse at t+1, no valido, busy stays 0.
  - num_samples=0 → done at t+1, no valido.
  - start during RUN → ignored.
- Abort and reset: abort at the cycle before the 3rd sample of num=8 → no further valido, no done.
  - Async rst low mid-sweep → all outputs 0 immediately.
  - A new sweep after release runs normally.
